// File: rtl/silu_stream_engine.sv
// Streams signed int8 elements from scratchpad SRAM through the 1-cycle SiLU ROM
// and writes the results back to a destination region, one element per cycle.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing one SRAM read per cycle
// DRAIN | reads finished, waiting for the last ROM result to be written
// DONE  | single-cycle completion pulse
module silu_stream_engine #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        lut_addr,
  input  logic [7:0]        lut_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] wr_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_cnt;
  logic              s1_valid;
  logic              s2_valid;

  assign cmd_ready = (state == IDLE) && !rst;

  // Data path is pass-through; idle cycles drive zeros instead of stale data.
  assign lut_addr = s1_valid ? rd_data : 8'h00;
  assign wr_en    = s2_valid;
  assign wr_data  = s2_valid ? lut_data : 8'h00;
  assign wr_addr  = s2_valid ? dst_q + wr_cnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dst_q    <= '0;
      len_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      s2_valid <= s1_valid;
      done     <= 1'b0;
      if (s2_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dst_q  <= cmd_dst;
            len_q  <= cmd_len;
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy   <= 1'b1;
            if (cmd_len != '0) begin
              state   <= RUN;
              rd_en   <= 1'b1;
              rd_addr <= cmd_src;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_cnt == len_q - 1'b1) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_cnt  <= rd_cnt + 1'b1;
            rd_addr <= rd_addr + 1'b1;
          end
        end
        // With s1 empty, the element now in s2 is the last write.
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
